// File: rtl/axis_uart_tx_core.sv
// AXI-Stream byte in, serial UART frame out: start, DATA_BITS LSB first,
// optional parity, STOP_BITS stop bits. Bit timing from an integer divider.
module axis_uart_tx_core #(
  parameter int unsigned BAUD_CLOCK_SPEED = 2000000,
  parameter int unsigned BAUD_RATE        = 250000,
  parameter int unsigned PARITY_ENA       = 0,
  parameter int unsigned PARITY_TYPE      = 0,
  parameter int unsigned STOP_BITS        = 1,
  parameter int unsigned DATA_BITS        = 8
) (
  input  logic       aclk,
  input  logic       arstn,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned DIV   = BAUD_CLOCK_SPEED / BAUD_RATE;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [7:0]       DATA_MASK = 8'((1 << DATA_BITS) - 1);

  // Reject configurations the frame logic cannot represent
  if (DIV < 2) begin : g_bad_div
    $error("axis_uart_tx_core: BAUD_CLOCK_SPEED/BAUD_RATE must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("axis_uart_tx_core: DATA_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("axis_uart_tx_core: STOP_BITS must be 1 or 2");
  end
  if (PARITY_TYPE > 3) begin : g_bad_parity_type
    $error("axis_uart_tx_core: PARITY_TYPE must be 0..3");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] baud_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             parity_q;
  logic             tx_q;
  logic             tready_q;
  logic             busy_q;

  // Parity bit for the active data bits of a byte
  function automatic logic parity_of(input logic [7:0] d);
    logic x;
    x = ^(d & DATA_MASK);
    case (PARITY_TYPE)
      0:       return x;
      1:       return ~x;
      2:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Frame sequencer: accepts a byte in IDLE, then walks each bit for DIV cycles
  always_ff @(posedge aclk) begin
    if (!arstn) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      tready_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q     <= 1'b1;
          busy_q   <= 1'b0;
          tready_q <= 1'b1;
          baud_q   <= '0;
          bit_q    <= '0;
          if (s_axis_tvalid && tready_q) begin
            shift_q  <= s_axis_tdata & DATA_MASK;
            parity_q <= parity_of(s_axis_tdata);
            tready_q <= 1'b0;
            busy_q   <= 1'b1;
            tx_q     <= 1'b0;
            state_q  <= S_START;
          end
        end
        default: begin
          if (baud_q != CNT_LAST) begin
            baud_q <= baud_q + 1'b1;
          end else begin
            baud_q <= '0;
            case (state_q)
              S_START: begin
                tx_q    <= shift_q[0];
                shift_q <= shift_q >> 1;
                bit_q   <= '0;
                state_q <= S_DATA;
              end
              S_DATA: begin
                if (bit_q != DATA_LAST) begin
                  tx_q    <= shift_q[0];
                  shift_q <= shift_q >> 1;
                  bit_q   <= bit_q + 1'b1;
                end else begin
                  bit_q <= '0;
                  if (PARITY_ENA != 0) begin
                    tx_q    <= parity_q;
                    state_q <= S_PARITY;
                  end else begin
                    tx_q    <= 1'b1;
                    state_q <= S_STOP;
                  end
                end
              end
              S_PARITY: begin
                tx_q    <= 1'b1;
                bit_q   <= '0;
                state_q <= S_STOP;
              end
              S_STOP: begin
                if (bit_q != STOP_LAST) begin
                  bit_q <= bit_q + 1'b1;
                end else begin
                  bit_q    <= '0;
                  tx_q     <= 1'b1;
                  tready_q <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= S_IDLE;
                end
              end
              default: state_q <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign s_axis_tready = tready_q;
  assign tx            = tx_q;
  assign busy          = busy_q;

endmodule
